// File: rtl/mem_master_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// operation codes, default geometry and the address legality check.
package mem_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int unsigned DEFAULT_DEPTH  = 1024;
  localparam int unsigned DEFAULT_STRIDE = 4;

  // An address is illegal when it is misaligned (if checked) or past the array.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input int unsigned depth,
                                    input bit          align_check);
    return (align_check && (addr[1:0] != 2'b00)) || (addr >= depth);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the address settle window.
// done is high whenever the count has reached zero.
module mem_wait_counter #(
  parameter  int unsigned WAIT_CYCLES = 1,
  localparam int unsigned CW          = $clog2(WAIT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          done
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/mem_master.sv
// Initiator-side access controller for the word-per-entry memory array.
// Both channels use strict valid/ready: a transfer happens on the rising edge
// where valid && ready; once raised, RespValid and its payload stay stable
// until consumed, and ReqReady depends only on the FSM state.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STRIDE      = DEFAULT_STRIDE,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  ReqLen,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespLast,
  output logic        RespErr,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWriteEnable,
  input  logic [31:0] MemData,
  output logic [1:0]  DbgState
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic        err_q, err_d;          // accept-time error riding through ACCESS
  logic [1:0]  beats_q, beats_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_last_q, resp_last_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_dec;
  logic          cnt_done;
  logic [31:0]   step_addr;
  logic          req_bad;
  logic          step_bad;

  assign step_addr = addr_q + 32'(STRIDE);
  assign req_bad   = addr_bad(ReqAddr, DEPTH, ALIGN_CHECK);
  assign step_bad  = addr_bad(step_addr, DEPTH, ALIGN_CHECK);

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ReqValid) state_d = ACCESS;
      ACCESS:  if (cnt_done) state_d = RESP;
      RESP: begin
        if (RespReady) begin
          if (beats_q == 2'd0) state_d = IDLE;
          else if (step_bad)   state_d = RESP;
          else                 state_d = ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request latching, read capture, burst stepping.
  // An accept-time error spends one cycle in ACCESS without touching memory
  // so its response lands one cycle after accept, like a single-wait read.
  always_comb begin
    addr_d       = addr_q;
    write_d      = write_q;
    err_d        = err_q;
    beats_d      = beats_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    resp_last_d  = resp_last_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_load     = 1'b0;
    cnt_load_val = WAIT_LOAD;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          addr_d   = ReqAddr;
          write_d  = ReqWrite;
          cnt_load = 1'b1;
          if (req_bad) begin
            err_d        = 1'b1;
            beats_d      = 2'd0;
            cnt_load_val = '0;
          end else begin
            err_d      = 1'b0;
            beats_d    = (ReqWrite == OP_WRITE) ? 2'd0 : ReqLen;
            mem_addr_d = ReqAddr;
            if (ReqWrite == OP_WRITE) mem_wdata_d = ReqWData;
          end
        end
      end
      ACCESS: begin
        if (cnt_done) begin
          if (err_q) begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            resp_last_d = 1'b1;
          end else begin
            resp_data_d = (write_q == OP_WRITE) ? 32'd0 : MemData;
            resp_err_d  = 1'b0;
            resp_last_d = (beats_q == 2'd0);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (RespReady && (beats_q != 2'd0)) begin
          addr_d = step_addr;
          if (step_bad) begin
            beats_d     = 2'd0;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            resp_last_d = 1'b1;
          end else begin
            beats_d    = beats_q - 2'd1;
            mem_addr_d = step_addr;
            cnt_load   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      beats_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      resp_last_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      err_q       <= err_d;
      beats_q     <= beats_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      resp_last_q <= resp_last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs decoded from state; write enable only on the final settle cycle.
  always_comb begin
    ReqReady       = (state_q == IDLE);
    RespValid      = (state_q == RESP);
    MemWriteEnable = (state_q == ACCESS) && (write_q == OP_WRITE) && !err_q && cnt_done;
    RespData       = resp_data_q;
    RespErr        = resp_err_q;
    RespLast       = resp_last_q;
    MemAddress     = mem_addr_q;
    MemWriteData   = mem_wdata_q;
    DbgState       = state_q;
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: a WAIT_CYCLES=1 instance for the main
// functions and a WAIT_CYCLES=3 instance for settle timing and mid-access reset.
module tb_mem_master;
  import mem_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst_n, req_valid, req_ready, req_write, resp_valid, resp_ready;
  logic        resp_last, resp_err, mem_we;
  logic [31:0] req_addr, req_wdata, resp_data, mem_address, mem_wdata, mem_data;
  logic [1:0]  req_len, dbg_state;

  logic        rst3, req_valid3, req_ready3, req_write3, resp_valid3, resp_ready3;
  logic        resp_last3, resp_err3, mem_we3;
  logic [31:0] req_addr3, req_wdata3, resp_data3, mem_address3, mem_wdata3, mem_data3;
  logic [1:0]  req_len3, dbg_state3;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  int we_cnt1 = 0;
  int we_cnt3 = 0;

  mem_master #(.WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset_n(rst_n), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqWrite(req_write), .ReqAddr(req_addr), .ReqWData(req_wdata), .ReqLen(req_len),
    .RespValid(resp_valid), .RespReady(resp_ready), .RespData(resp_data),
    .RespLast(resp_last), .RespErr(resp_err), .MemAddress(mem_address),
    .MemWriteData(mem_wdata), .MemWriteEnable(mem_we), .MemData(mem_data),
    .DbgState(dbg_state)
  );

  mem_master #(.WAIT_CYCLES(3)) dut3 (
    .Clk(Clk), .Reset_n(rst3), .ReqValid(req_valid3), .ReqReady(req_ready3),
    .ReqWrite(req_write3), .ReqAddr(req_addr3), .ReqWData(req_wdata3), .ReqLen(req_len3),
    .RespValid(resp_valid3), .RespReady(resp_ready3), .RespData(resp_data3),
    .RespLast(resp_last3), .RespErr(resp_err3), .MemAddress(mem_address3),
    .MemWriteData(mem_wdata3), .MemWriteEnable(mem_we3), .MemData(mem_data3),
    .DbgState(dbg_state3)
  );

  // Memory models: combinational read, write on the edge ending the enable cycle.
  assign mem_data  = mem1[mem_address[9:0]];
  assign mem_data3 = mem3[mem_address3[9:0]];
  always @(posedge Clk) begin
    if (mem_we)  begin mem1[mem_address[9:0]]  <= mem_wdata;  we_cnt1 <= we_cnt1 + 1; end
    if (mem_we3) begin mem3[mem_address3[9:0]] <= mem_wdata3; we_cnt3 <= we_cnt3 + 1; end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks (dut1) ----------------
  task automatic send_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] len);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_len = len;
    while (!req_ready && n < 20) begin @(posedge Clk); #1; n++; end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    @(posedge Clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_beat(input int stall, output logic [31:0] data, output logic err,
                          output logic last, output logic [31:0] addr, output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin @(posedge Clk); #1; lat++; end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    data = resp_data; err = resp_err; last = resp_last; addr = mem_address;
    for (int i = 0; i < stall; i++) begin
      @(posedge Clk); #1;
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_data", resp_data, data);
      check("stall_last", 32'(resp_last), 32'(last));
    end
    resp_ready = 1'b1;
    @(posedge Clk); #1;
    resp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d, a;
  logic        e, l;
  int          lat, w0, v3;

  initial begin
    for (int i = 0; i < 1024; i++) begin mem1[i] <= 32'd0; mem3[i] <= 32'd0; end
    mem1[128]  <= 32'h8c030000;
    mem1[132]  <= 32'h8c040001;
    mem1[136]  <= 32'h8c050002;
    mem1[140]  <= 32'h8c010002;
    mem1[1020] <= 32'hcafe0123;
    mem3[16]   <= 32'h00000077;
    rst_n = 1'b0; rst3 = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_len = 0; resp_ready = 0;
    req_valid3 = 0; req_write3 = 0; req_addr3 = 0; req_wdata3 = 0; req_len3 = 0; resp_ready3 = 0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_addr = $urandom; req_wdata = $urandom; req_len = 2'($urandom_range(0, 3));
      resp_ready = 1'($urandom_range(0, 1));
    end
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_last", 32'(resp_last), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_addr", mem_address, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_len = 0; resp_ready = 0;
    @(posedge Clk); #1;
    rst_n = 1'b1; rst3 = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // Single read
    send_req(OP_READ, 32'd128, 32'd0, 2'd0);
    check("rd_access_addr", mem_address, 32'd128);
    check("rd_access_state", 32'(dbg_state), 32'(ACCESS));
    check("rd_busy_ready", 32'(req_ready), 32'd0);
    check("rd_access_valid", 32'(resp_valid), 32'd0);
    get_beat(0, d, e, l, a, lat);
    check("rd_lat", 32'(lat), 32'd1);
    check("rd_data", d, 32'h8c030000);
    check("rd_last", 32'(l), 32'd1);
    check("rd_err", 32'(e), 32'd0);
    check("rd_done_valid", 32'(resp_valid), 32'd0);
    check("rd_done_ready", 32'(req_ready), 32'd1);

    // Burst of 4 with backpressure on beat 2
    exp_q.push_back(32'h8c030000); exp_q.push_back(32'h8c040001);
    exp_q.push_back(32'h8c050002); exp_q.push_back(32'h8c010002);
    send_req(OP_READ, 32'd128, 32'd0, 2'd3);
    for (int i = 0; i < 4; i++) begin
      get_beat((i == 1) ? 2 : 0, d, e, l, a, lat);
      check("burst_data", d, exp_q.pop_front());
      check("burst_addr", a, 32'(128 + 4 * i));
      check("burst_last", 32'(l), (i == 3) ? 32'd1 : 32'd0);
      check("burst_err", 32'(e), 32'd0);
      check("burst_lat", 32'(lat), 32'd1);
    end
    check("burst_idle", 32'(req_ready), 32'd1);

    // Store then load (ReqLen ignored for stores)
    w0 = we_cnt1;
    send_req(OP_WRITE, 32'd8, 32'h15, 2'd3);
    check("st_we", 32'(mem_we), 32'd1);
    check("st_wdata", mem_wdata, 32'h15);
    check("st_addr", mem_address, 32'd8);
    get_beat(0, d, e, l, a, lat);
    check("st_resp_data", d, 32'd0);
    check("st_resp_last", 32'(l), 32'd1);
    check("st_resp_err", 32'(e), 32'd0);
    check("st_we_count", 32'(we_cnt1 - w0), 32'd1);
    check("st_mem", mem1[8], 32'h15);
    send_req(OP_READ, 32'd8, 32'd0, 2'd0);
    get_beat(0, d, e, l, a, lat);
    check("ld_after_st", d, 32'h15);

    // Misaligned store
    w0 = we_cnt1;
    send_req(OP_WRITE, 32'd6, 32'hdeadbeef, 2'd0);
    check("mis_st_we", 32'(mem_we), 32'd0);
    check("mis_st_no_addr", mem_address, 32'd8);
    get_beat(0, d, e, l, a, lat);
    check("mis_st_lat", 32'(lat), 32'd1);
    check("mis_st_err", 32'(e), 32'd1);
    check("mis_st_last", 32'(l), 32'd1);
    check("mis_st_data", d, 32'd0);
    check("mis_st_we_count", 32'(we_cnt1 - w0), 32'd0);

    // Out of range read
    send_req(OP_READ, 32'd1024, 32'd0, 2'd2);
    get_beat(0, d, e, l, a, lat);
    check("oor_lat", 32'(lat), 32'd1);
    check("oor_err", 32'(e), 32'd1);
    check("oor_last", 32'(l), 32'd1);
    check("oor_idle", 32'(req_ready), 32'd1);

    // Burst running off the end
    send_req(OP_READ, 32'd1020, 32'd0, 2'd1);
    get_beat(0, d, e, l, a, lat);
    check("edge_b1_data", d, 32'hcafe0123);
    check("edge_b1_last", 32'(l), 32'd0);
    check("edge_b1_err", 32'(e), 32'd0);
    get_beat(0, d, e, l, a, lat);
    check("edge_b2_err", 32'(e), 32'd1);
    check("edge_b2_last", 32'(l), 32'd1);
    check("edge_b2_data", d, 32'd0);
    check("edge_idle", 32'(req_ready), 32'd1);

    // WAIT_CYCLES=3: normal store timing
    req_valid3 = 1'b1; req_write3 = OP_WRITE; req_addr3 = 32'd20; req_wdata3 = 32'h99;
    @(posedge Clk); #1;
    req_valid3 = 1'b0;
    check("w3_we_c0", 32'(mem_we3), 32'd0);
    @(posedge Clk); #1;
    check("w3_we_c1", 32'(mem_we3), 32'd0);
    @(posedge Clk); #1;
    check("w3_we_c2", 32'(mem_we3), 32'd1);
    check("w3_valid_c2", 32'(resp_valid3), 32'd0);
    @(posedge Clk); #1;
    check("w3_valid_c3", 32'(resp_valid3), 32'd1);
    check("w3_mem", mem3[20], 32'h99);
    resp_ready3 = 1'b1;
    @(posedge Clk); #1;
    resp_ready3 = 1'b0;
    check("w3_idle", 32'(req_ready3), 32'd1);

    // WAIT_CYCLES=3: reset during store ACCESS
    w0 = we_cnt3;
    v3 = 0;
    req_valid3 = 1'b1; req_write3 = OP_WRITE; req_addr3 = 32'd16; req_wdata3 = 32'haa;
    @(posedge Clk); #1;
    req_valid3 = 1'b0;
    check("rst3_access", 32'(dbg_state3), 32'(ACCESS));
    @(posedge Clk); #1;
    rst3 = 1'b0;
    #1;
    check("rst3_we", 32'(mem_we3), 32'd0);
    check("rst3_state", 32'(dbg_state3), 32'(IDLE));
    check("rst3_mem_addr", mem_address3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      if (resp_valid3 || mem_we3) v3++;
    end
    rst3 = 1'b1;
    @(posedge Clk); #1;
    check("rst3_ready", 32'(req_ready3), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (resp_valid3 || mem_we3) v3++;
    end
    check("rst3_no_activity", 32'(v3), 32'd0);
    check("rst3_we_count", 32'(we_cnt3 - w0), 32'd0);
    check("rst3_mem", mem3[16], 32'h77);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_master.md
# mem_master

Initiator-side access controller for the word-per-entry `Memory` array in the multicycle MIPS core. It accepts fetch, load and store requests from the datapath over a valid/ready handshake and drives the memory's address, write-data and write-enable lines. It holds the address stable for a programmable number of settle cycles, then captures read data. Results return to the datapath over a second valid/ready channel, with optional short read bursts for instruction prefetch.

## Interface
Parameters:
- `DEPTH`, 1024: number of memory entries; any address `>= DEPTH` is out of range.
- `WAIT_CYCLES`, 1: cycles the address is held before read capture or write commit; must be `>= 1`.
- `STRIDE`, 4: address increment between burst beats, matching the byte-spaced instruction image.
- `ALIGN_CHECK`, 1: when 1, an address with `addr[1:0] != 0` is an error.

Ports:
- `Clk` in 1: clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: request accepted on the edge where `ReqValid && ReqReady`.
- `ReqWrite` in 1: 1 = store, 0 = read.
- `ReqAddr` in 32: start address.
- `ReqWData` in 32: store data.
- `ReqLen` in 2: read beats minus 1 (1 to 4 beats); ignored for stores, which are always 1 beat.
- `RespValid` out 1: response beat present.
- `RespReady` in 1: beat consumed on the edge where `RespValid && RespReady`.
- `RespData` out 32: read data; 0 for stores and errors.
- `RespLast` out 1: final beat of the request.
- `RespErr` out 1: beat is an error.
- `MemAddress` out 32: to `Memory.Address`.
- `MemWriteData` out 32: to `Memory.writeData`.
- `MemWriteEnable` out 1: to `Memory.writeEnable`.
- `MemData` in 32: from `Memory.MemData` (combinational read).

## Operation
- States:
  - IDLE: `ReqReady=1`.
  - ACCESS: wait count running.
  - RESP: `RespValid=1`.
- IDLE → ACCESS on accept: latch addr, wdata, write flag, beats-remaining = `ReqLen` (0 for stores).
- Error checks run at accept and at every burst step. An error is a misaligned address (when `ALIGN_CHECK=1`) or `addr >= DEPTH`.
- On error, go straight to RESP with `RespErr=1`, `RespLast=1`, `RespData=0`. No memory cycle and no write enable occur. The remaining burst beats are discarded.
- ACCESS:
  - `MemAddress` = current addr.
  - Counter loads `WAIT_CYCLES-1` and decrements.
  - On the count-0 cycle, a store asserts `MemWriteEnable` (and `MemWriteData` = latched wdata) for exactly that cycle.
  - On the count-0 edge, reads capture `MemData` into `RespData`. Then go to RESP.
- RESP: `RespValid=1`; outputs are held stable until `RespReady`.
  - On consume with beats-remaining > 0: decrement, addr += `STRIDE` (32-bit wrap is irrelevant because the range check fires first), go to ACCESS, or to RESP with error if the new addr fails the check.
  - On consume otherwise: go to IDLE.
- `RespLast=1` on the final beat, whether normal or error.
- `MemAddress` and `MemWriteData` hold their last values outside ACCESS.
- No overlap: `ReqReady=0` outside IDLE. A new request can be accepted in the cycle after the last beat is consumed.

## Timing
- Reset values:
  - State IDLE, `ReqReady=1`.
  - `RespValid=0`, `RespData=0`, `RespLast=0`, `RespErr=0`.
  - `MemAddress=0`, `MemWriteData=0`, `MemWriteEnable=0`.
  - Counter 0, beats-remaining 0.
- Accept at edge k: ACCESS covers cycles k..k+`WAIT_CYCLES`-1. `RespValid` rises after edge k+`WAIT_CYCLES`.
- Error latency: `RespValid` rises after edge k+1.
- Burst: each further beat costs `WAIT_CYCLES` cycles after the consume edge. Back-to-back consumption with `WAIT_CYCLES=1` gives one beat per 2 cycles.
- Store commit: the memory writes on the edge that ends the `MemWriteEnable` cycle. That is the same edge on which the FSM leaves ACCESS.
- Reset asserted mid-operation: all outputs clear immediately (asynchronously). `MemWriteEnable` drops, so no write commits at the next edge. The in-flight request is dropped with no response.
- `ReqValid` held with the FSM busy: no accept and no side effects.

## Structure
- Shared package `mem_master_pkg` holds:
  - State encoding `IDLE`/`ACCESS`/`RESP` (2-bit).
  - `OP_READ`/`OP_WRITE` constants.
  - Default `DEPTH`, `STRIDE`.
- One sub-module, `mem_wait_counter`: loadable down-counter of width `$clog2(WAIT_CYCLES+1)` with a `done` output. It uses the same clock and reset.

## Test plan
- Reset: hold `Reset_n=0` with random inputs → every output at its reset value; `ReqReady=1` on the first cycle after release.
- Single read: preload entry 128 = `32'h8c030000`, `WAIT_CYCLES=1`, accept read addr 128 → `MemAddress=128` for 1 cycle. `RespValid` follows 1 cycle after accept with `RespData=32'h8c030000`, `RespLast=1`, `RespErr=0`.
- Burst with backpressure: entries 128/132/136/140 = `8c030000`/`8c040001`/`8c050002`/`8c010002`, `ReqLen=3`, `RespReady` low for 2 cycles on beat 2 → 4 beats in order. `MemAddress` goes 128, 132, 136, 140. Beat 2 is held stable while stalled. `RespLast` is set only on beat 4.
- Store then load: write `32'h15` to addr 8 → `MemWriteEnable` high for exactly 1 cycle; a read of addr 8 then returns `32'h15`. Store to addr 6 → `RespErr=1`, `MemWriteEnable` never asserted.
- Range: read addr 1024 → error 1 cycle after accept. Burst from 1020 with `ReqLen=1` → beat 1 returns data with `RespLast=0`; beat 2 is an error with `RespLast=1`.
- Reset during store ACCESS (`WAIT_CYCLES=3`, reset asserted in cycle 2) → `MemWriteEnable` stays 0, the target entry is unchanged, and no `RespValid` appears; after release, `ReqReady=1`.
